serializer_arbiter: RTL and testbench
=====================================

# serializer_arbiter

Round-robin arbiter and load sequencer that shares one 16-bit-to-2-bit `serializer` between NUM_REQ upstream sources. It accepts words over per-requester valid/ready handshakes and locks the grant to one source until that source marks a word as last, so frames are never interleaved. It paces `load_en` pulses exactly SYMS_PER_WORD cycles apart, which lets the serializer stream continuously. It sits directly in front of `serializer` in the TX symbol path.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, parallel word width; must match serializer `p_in`
- SYMS_PER_WORD, 8, serializer cycles per word (DATA_W/2)
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_last  in  NUM_REQ  per-requester last-word-of-frame flag; qualified by valid
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester accept, combinational from registered state
- ser_load_en  out  1  one-cycle load pulse to the serializer `load_en` (registered)
- ser_p_in  out  DATA_W  word to the serializer `p_in` (registered)
- grant_valid  out  1  a requester currently owns the serializer
- grant_id  out  $clog2(NUM_REQ)  owning requester index
- busy  out  1  grant held, countdown running, or load pulse pending

## Operation
- FSM states:
  - IDLE: no grant.
  - LOCK: grant held.
- Reset: state IDLE, rr_ptr=0, cnt=0, ser_load_en=0, ser_p_in=0, grant_valid=0, grant_id=0, req_ready=0, busy=0. A reset mid-word drops the word in flight; no further load pulse is issued.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register it into grant_id, set grant_valid, and go to LOCK.
  - Arbitration does not wait for cnt.
- LOCK:
  - req_ready[grant_id] = (cnt==0). All other req_ready bits are 0.
  - Accept = req_valid[grant_id] && req_ready[grant_id].
  - On accept: ser_p_in <= the granted word, ser_load_en <= 1 for one cycle, cnt <= SYMS_PER_WORD-1.
  - If req_last[grant_id] is set on accept: go to IDLE, grant_valid <= 0, rr_ptr <= (grant_id+1) mod NUM_REQ.
  - If the granted requester deasserts valid without sending last, the grant is held indefinitely. Other requesters wait.
- cnt:
  - Decrements by 1 each cycle while nonzero, independent of state.
  - Never wraps below 0.
- busy = grant_valid || (cnt!=0) || ser_load_en.
- req_valid from non-granted requesters is ignored and needs no stability. req_data and req_last are sampled only on accept.

## Timing
- Accept in cycle A gives ser_load_en=1 and ser_p_in valid in cycle A+1.
- Back-to-back words from the granted source:
  - Accepts occur at A, A+8, A+16, … with SYMS_PER_WORD=8.
  - Load pulses occur at A+1, A+9, …, exactly SYMS_PER_WORD apart.
  - The serializer must accept a reload on the cycle after its last symbol.
- New grant latency:
  - req_valid seen in IDLE at cycle T gives grant_valid=1 at T+1.
  - The earliest accept is T+1 if cnt==0 then; otherwise it is the first cycle with cnt==0.
- Frame handoff:
  - Last accepted at A: IDLE at A+1, next grant at A+2, next accept at A+8.
  - The next load is at A+9, so there is no gap in the stream.
- Simultaneous requests:
  - The winner is the nearest index at or above rr_ptr.
  - A requester asserting valid while another holds the grant waits for that frame's last.
- Single-word frame (valid and last together): grant is released one cycle after accept.

## Test plan
- Reset, then req_valid[0]=1, last=1, data 0xABCD at T → grant_id=0 at T+1, accept T+1, ser_load_en=1 with ser_p_in=0xABCD at T+2, busy falls at T+9.
- Requester 1 sends a 3-word frame 0x1111/0x2222/0x3333 (last on the third), valid held → load pulses exactly 8 cycles apart, grant_valid drops the cycle after the third accept.
- Requesters 0, 2 and 3 all valid with single-word frames from reset → grants in order 0, 2, 3, then 0 again if it is still valid. Loads are 8 cycles apart with no idle cycle between frames.
- Requester 2 holds the grant and deasserts valid for 20 cycles mid-frame while requester 3 is valid → no load pulses, req_ready[3]=0 throughout, and requester 2 resumes with 0x1234 as the next load.
- rst asserted 3 cycles after an accept of 0xBEEF → next cycle all outputs return to reset values, no further ser_load_en, and rr_ptr=0, so requester 0 wins the next contention.
- Word accepted with last while requester 1 is already valid → grant for requester 1 is registered during the countdown, its first accept lands exactly at cnt==0, and the load spacing stays 8.

Source files
------------

// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that shares one serializer between NUM_REQ sources.
// Grants are held for a whole frame; load pulses are paced SYMS_PER_WORD apart.
module serializer_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 16,
    parameter int SYMS_PER_WORD = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        ser_load_en,
    output logic [DATA_W-1:0]           ser_p_in,
    output logic                        grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    // state | meaning
    // IDLE  | no requester owns the serializer
    // LOCK  | grant held until the owner sends a word marked last
    typedef enum logic {IDLE, LOCK} state_t;

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(SYMS_PER_WORD + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SYMS_PER_WORD - 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ser_load_en_q, ser_load_en_d;
    logic [DATA_W-1:0]   ser_p_in_q, ser_p_in_d;
    logic                accept;
    logic [ID_W-1:0]     next_ptr;
    logic [DATA_W-1:0]   word_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign word_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Lowest offset from ptr wins, so iterate from the far end and overwrite.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] sel;
        int              idx;
        sel = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (v[ID_W'(idx)]) sel = ID_W'(idx);
        end
        return sel;
    endfunction

    assign next_ptr = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        ser_p_in_d    = ser_p_in_q;
        ser_load_en_d = 1'b0;
        cnt_d         = cnt_q;
        req_ready     = '0;
        accept        = 1'b0;

        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);

        case (state_q)
            IDLE: begin
                // Arbitration runs in parallel with the countdown of the last word.
                if (|req_valid) begin
                    grant_id_d = rr_pick(req_valid, rr_ptr_q);
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                req_ready[grant_id_q] = (cnt_q == '0);
                accept = req_valid[grant_id_q] && (cnt_q == '0);
                if (accept) begin
                    ser_p_in_d    = word_arr[grant_id_q];
                    ser_load_en_d = 1'b1;
                    cnt_d         = CNT_LOAD;
                    if (req_last[grant_id_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            cnt_q         <= '0;
            ser_load_en_q <= 1'b0;
            ser_p_in_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            cnt_q         <= cnt_d;
            ser_load_en_q <= ser_load_en_d;
            ser_p_in_q    <= ser_p_in_d;
        end
    end

    assign grant_valid = (state_q == LOCK);
    assign grant_id    = grant_id_q;
    assign ser_load_en = ser_load_en_q;
    assign ser_p_in    = ser_p_in_q;
    assign busy        = grant_valid || (cnt_q != '0) || ser_load_en_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Bench for serializer_arbiter: vector table, directed frame scenarios and
// randomized traffic checked against a cycle-count based reference model.
module tb_serializer_arbiter;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int SYMS = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic            ser_load_en, grant_valid, busy;
    logic [DW-1:0]   ser_p_in;
    logic [1:0]      grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serializer_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SYMS_PER_WORD(SYMS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .ser_load_en(ser_load_en), .ser_p_in(ser_p_in),
        .grant_valid(grant_valid), .grant_id(grant_id), .busy(busy)
    );

    // Reference model: owner index (-1 = none), round-robin pointer and the
    // cycle number of the most recent accept; readiness is pure time arithmetic.
    int            m_owner, m_rr, m_last_acc, cyc;
    logic [DW-1:0] m_p;
    bit            m_acc, chk_en;
    int            ld_cyc[$];
    logic [DW-1:0] ld_word[$];

    typedef struct {
        int         n;
        logic [3:0] v;
        logic [3:0] l;
        logic [15:0] d;
        logic       gv;
        logic [1:0] gid;
        logic [3:0] rdy;
        logic       ld;
        logic [15:0] p;
        logic       busy;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_check();
        logic [N-1:0] e_rdy;
        logic e_gv, e_ld, e_busy;
        e_gv = (m_owner >= 0);
        for (int i = 0; i < N; i++) e_rdy[i] = (m_owner == i) && (cyc >= m_last_acc + SYMS);
        e_ld   = (cyc == m_last_acc + 1);
        e_busy = e_gv || (cyc > m_last_acc && cyc < m_last_acc + SYMS);
        chk("m_grant_valid", 32'(grant_valid), 32'(e_gv));
        if (e_gv) chk("m_grant_id", 32'(grant_id), 32'(m_owner));
        chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
        chk("m_load_en", 32'(ser_load_en), 32'(e_ld));
        chk("m_p_in", 32'(ser_p_in), 32'(m_p));
        chk("m_busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic model_step();
        bit found;
        m_acc = 1'b0;
        if (rst) begin
            m_owner = -1; m_rr = 0; m_last_acc = -100; m_p = '0;
        end else if (m_owner >= 0) begin
            if (req_valid[m_owner] && cyc >= m_last_acc + SYMS) begin
                m_acc      = 1'b1;
                m_last_acc = cyc;
                m_p        = req_data[m_owner*DW +: DW];
                if (req_last[m_owner]) begin
                    m_rr    = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                int idx = (m_rr + k) % N;
                if (!found && req_valid[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        if (chk_en) model_check();
        if (ser_load_en) begin
            ld_cyc.push_back(cyc);
            ld_word.push_back(ser_p_in);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic tick_until_accept(input int max, input string nm);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!m_acc && k < max);
        chk(nm, 32'(m_acc), 32'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        ld_cyc.delete(); ld_word.delete();
    endtask

    task automatic set_word(input int i, input logic [DW-1:0] w);
        req_data[i*DW +: DW] = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rr_exp [4];
        cyc = 0; chk_en = 1'b0; m_acc = 1'b0;
        m_owner = -1; m_rr = 0; m_last_acc = -100; m_p = '0;

        //             n  v     l     d         gv  gid  rdy   ld  p          busy
        tbl[0]  = '{1, 4'h1, 4'h1, 16'hABCD, 0, 2'd0, 4'h0, 0, 16'h0000, 0};
        tbl[1]  = '{1, 4'h1, 4'h1, 16'hABCD, 1, 2'd0, 4'h1, 0, 16'h0000, 1};
        tbl[2]  = '{1, 4'h0, 4'h0, 16'h0000, 0, 2'd0, 4'h0, 1, 16'hABCD, 1};
        tbl[3]  = '{6, 4'h0, 4'h0, 16'h0000, 0, 2'd0, 4'h0, 0, 16'hABCD, 1};
        tbl[4]  = '{1, 4'h2, 4'h2, 16'h5A5A, 0, 2'd0, 4'h0, 0, 16'hABCD, 0};
        tbl[5]  = '{1, 4'h2, 4'h2, 16'h5A5A, 1, 2'd1, 4'h2, 0, 16'hABCD, 1};
        tbl[6]  = '{1, 4'h4, 4'h4, 16'hC3C3, 0, 2'd0, 4'h0, 1, 16'h5A5A, 1};
        tbl[7]  = '{6, 4'h4, 4'h4, 16'hC3C3, 1, 2'd2, 4'h0, 0, 16'h5A5A, 1};
        tbl[8]  = '{1, 4'h4, 4'h4, 16'hC3C3, 1, 2'd2, 4'h4, 0, 16'h5A5A, 1};
        tbl[9]  = '{1, 4'h0, 4'h0, 16'h0000, 0, 2'd0, 4'h0, 1, 16'hC3C3, 1};
        tbl[10] = '{6, 4'h0, 4'h0, 16'h0000, 0, 2'd0, 4'h0, 0, 16'hC3C3, 1};
        tbl[11] = '{1, 4'h0, 4'h0, 16'h0000, 0, 2'd0, 4'h0, 0, 16'hC3C3, 0};

        do_reset();
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                req_valid = tbl[r].v;
                req_last  = tbl[r].l;
                req_data  = {4{tbl[r].d}};
                sample();
                chk($sformatf("tbl%0d_gv", r), 32'(grant_valid), 32'(tbl[r].gv));
                if (tbl[r].gv) chk($sformatf("tbl%0d_gid", r), 32'(grant_id), 32'(tbl[r].gid));
                chk($sformatf("tbl%0d_rdy", r), 32'(req_ready), 32'(tbl[r].rdy));
                chk($sformatf("tbl%0d_ld", r), 32'(ser_load_en), 32'(tbl[r].ld));
                chk($sformatf("tbl%0d_p", r), 32'(ser_p_in), 32'(tbl[r].p));
                chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
                advance();
            end
        end

        // Three-word frame from requester 1 with valid held throughout.
        do_reset();
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            set_word(1, 16'(32'h1111 * (k + 1)));
            req_last = (k == 2) ? 4'b0010 : 4'b0000;
            tick_until_accept(20, "frame3_accept");
        end
        req_valid = '0; req_last = '0;
        sample();
        chk("frame3_release", 32'(grant_valid), 32'(0));
        advance();
        repeat (3) tick();
        chk("frame3_nloads", 32'(ld_cyc.size()), 32'(3));
        if (ld_cyc.size() == 3) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("frame3_word%0d", k), 32'(ld_word[k]), 32'h1111 * (k + 1));
            chk("frame3_gap01", 32'(ld_cyc[1] - ld_cyc[0]), 32'(SYMS));
            chk("frame3_gap12", 32'(ld_cyc[2] - ld_cyc[1]), 32'(SYMS));
        end

        // Requesters 0, 2, 3 contending with single-word frames.
        do_reset();
        for (int i = 0; i < N; i++) set_word(i, 16'hA000 + 16'(i));
        req_valid = 4'b1101; req_last = 4'b1101;
        repeat (40) tick();
        req_valid = '0; req_last = '0;
        rr_exp[0] = 16'hA000; rr_exp[1] = 16'hA002; rr_exp[2] = 16'hA003; rr_exp[3] = 16'hA000;
        chk("rr_enough_loads", 32'(ld_cyc.size() >= 4), 32'(1));
        if (ld_cyc.size() >= 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("rr_word%0d", k), 32'(ld_word[k]), 32'(rr_exp[k]));
            for (int k = 1; k < 4; k++)
                chk($sformatf("rr_gap%0d", k), 32'(ld_cyc[k] - ld_cyc[k-1]), 32'(SYMS));
        end

        // Granted requester 2 stalls mid-frame while requester 3 waits.
        do_reset();
        set_word(2, 16'hAAAA); set_word(3, 16'h3333);
        req_valid = 4'b0100; req_last = 4'b0000;
        tick_until_accept(10, "stall_first_accept");
        req_valid = 4'b1000; req_last = 4'b1000;
        tick();
        ld_cyc.delete(); ld_word.delete();
        for (int k = 0; k < 20; k++) begin
            sample();
            chk("stall_ready3", 32'(req_ready[3]), 32'(0));
            advance();
        end
        chk("stall_no_loads", 32'(ld_cyc.size()), 32'(0));
        set_word(2, 16'h1234);
        req_valid = 4'b1100; req_last = 4'b1100;
        tick_until_accept(10, "stall_resume_accept");
        req_valid = 4'b1000;
        tick();
        chk("stall_resume_nload", 32'(ld_word.size() >= 1), 32'(1));
        if (ld_word.size() >= 1) chk("stall_resume_word", 32'(ld_word[0]), 32'h1234);
        req_valid = '0; req_last = '0;
        repeat (20) tick();

        // Reset three cycles after accepting 0xBEEF.
        do_reset();
        set_word(2, 16'hBEEF);
        req_valid = 4'b0100; req_last = 4'b0100;
        tick_until_accept(10, "rst_accept");
        req_valid = '0; req_last = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ld_cyc.delete(); ld_word.delete();
        sample();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_p_in", 32'(ser_p_in), 32'(0));
        chk("rst_load_en", 32'(ser_load_en), 32'(0));
        chk("rst_grant_valid", 32'(grant_valid), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        advance();
        repeat (8) tick();
        chk("rst_no_loads", 32'(ld_cyc.size()), 32'(0));
        req_valid = 4'b1001; req_last = 4'b1001;
        tick();
        sample();
        chk("rst_rr_gv", 32'(grant_valid), 32'(1));
        chk("rst_rr_winner", 32'(grant_id), 32'(0));
        advance();
        req_valid = '0; req_last = '0;
        repeat (12) tick();

        // Randomized traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 149) == 0);
            req_valid = 4'($urandom);
            req_last  = 4'($urandom) & 4'($urandom);
            req_data  = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0; req_valid = '0; req_last = '0;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
